// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake,
// resolves branch/jump targets and commits the next PC after each instruction.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic [1:0]  branch,
  input  logic        jump,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        stall,
  output logic        addr_err
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;
  localparam int unsigned IMMW = 16;
  localparam int unsigned TGTW = 26;

  localparam logic [OPW-1:0] OP_SPECIAL = 6'b000000;
  localparam logic [OPW-1:0] OP_BEQ     = 6'b000100;
  localparam logic [OPW-1:0] OP_BNE     = 6'b000101;
  localparam logic [OPW-1:0] OP_BLEZ    = 6'b000110;
  localparam logic [OPW-1:0] OP_BGTZ    = 6'b000111;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BGEZ = 2'b01;
  localparam logic [1:0] BR_BLTZ = 2'b10;
  localparam logic [1:0] BR_CMP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ins_q, ins_d;
  logic              imem_req_q, imem_req_d;
  logic              ins_valid_q, ins_valid_d;

  logic [OPW-1:0]    op;
  logic [XLEN-1:0]   imm_off;
  logic [XLEN-1:0]   br_target;
  logic [XLEN-1:0]   jmp_target;
  logic [XLEN-1:0]   npc;
  logic              rs_zero;
  logic              taken;

  // Next-PC resolution from the instruction currently in EXEC.
  always_comb begin
    op         = ins_q[31:26];
    imm_off    = {{(XLEN-IMMW-2){ins_q[IMMW-1]}}, ins_q[IMMW-1:0], 2'b00};
    br_target  = pc_q + 32'd4 + imm_off;
    jmp_target = {pc_plus4[31:28], ins_q[TGTW-1:0], 2'b00};
    rs_zero    = (rs_data == '0);
    taken      = 1'b0;
    case (branch)
      BR_NONE: taken = 1'b0;
      BR_BGEZ: taken = ~rs_data[XLEN-1];
      BR_BLTZ: taken = rs_data[XLEN-1];
      BR_CMP: begin
        case (op)
          OP_BEQ:  taken = (rs_data == rt_data);
          OP_BNE:  taken = (rs_data != rt_data);
          OP_BLEZ: taken = rs_data[XLEN-1] | rs_zero;
          OP_BGTZ: taken = ~rs_data[XLEN-1] & ~rs_zero;
          default: taken = 1'b0;
        endcase
      end
      default: taken = 1'b0;
    endcase

    npc = pc_q + 32'd4;
    if (jump) begin
      npc = (op == OP_SPECIAL) ? rs_data : jmp_target;
    end else if (taken) begin
      npc = br_target;
    end
  end

  // Fetch/execute sequencing; req and valid flops mirror the next state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ins_d    = ins_q;
    addr_err = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ins_d   = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d     = {npc[XLEN-1:2], 2'b00};
          addr_err = |npc[1:0];
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    imem_req_d  = (state_d == S_FETCH);
    ins_valid_d = (state_d == S_EXEC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ins_q       <= '0;
      imem_req_q  <= 1'b0;
      ins_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      imem_req_q  <= imem_req_d;
      ins_valid_q <= ins_valid_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign ins       = ins_q;
  assign ins_valid = ins_valid_q;
  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;

endmodule
